// File: rtl/vscale_rr_dmem_arbiter_pkg.sv
// Shared HASTI constants and helpers for the round-robin dmem arbiter.
// Transfer-type encodings and field widths match the vscale HASTI bus.
package vscale_rr_dmem_arbiter_pkg;

  localparam int HASTI_TRANS_WIDTH = 2;
  localparam int HASTI_SIZE_WIDTH  = 3;
  localparam int HASTI_BURST_WIDTH = 3;
  localparam int HASTI_PROT_WIDTH  = 4;
  localparam int HASTI_RESP_WIDTH  = 1;

  localparam logic [1:0] HASTI_TRANS_IDLE   = 2'b00;
  localparam logic [1:0] HASTI_TRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HASTI_TRANS_SEQ    = 2'b11;

  localparam logic HASTI_RESP_OKAY = 1'b0;

  function automatic logic hasti_is_req(
    input logic [HASTI_TRANS_WIDTH-1:0] t
  );
    return (t == HASTI_TRANS_NONSEQ) ||
           (t == HASTI_TRANS_SEQ);
  endfunction

endpackage

// File: rtl/vscale_rr_dmem_arbiter_pick.sv
// Combinational round-robin picker: first requester after ptr_i, wrapping.
// Produces the winning index and a valid flag.
module vscale_rr_pick #(
  parameter int N  = 2,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [IW-1:0] gnt_idx_o,
  output logic          gnt_vld_o
);

  logic [IW-1:0] cand;

  always_comb begin
    gnt_vld_o = 1'b0;
    gnt_idx_o = '0;
    cand      = '0;
    for (int k = 1; k <= N; k++) begin
      cand = IW'((int'(ptr_i) + k) % N);
      if (!gnt_vld_o && req_i[cand]) begin
        gnt_vld_o = 1'b1;
        gnt_idx_o = cand;
      end
    end
  end

endmodule

// File: rtl/vscale_rr_dmem_arbiter.sv
// N:1 HASTI dmem arbiter with data-phase tracking and held responses.
// Define VSCALE_ARB_FORCED_SCHED_EN to grant from next_core instead of RR.
module vscale_rr_dmem_arbiter
  import vscale_rr_dmem_arbiter_pkg::*;
#(
  parameter int NUM_CORES  = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int BUS_WIDTH  = 32,
  localparam int CORE_IDX_WIDTH = $clog2(NUM_CORES)
) (
  input  logic hclk,
  input  logic hresetn,
  input  logic [NUM_CORES*ADDR_WIDTH-1:0] core_haddr,
  input  logic [NUM_CORES-1:0] core_hwrite,
  input  logic [NUM_CORES*HASTI_SIZE_WIDTH-1:0] core_hsize,
  input  logic [NUM_CORES*HASTI_BURST_WIDTH-1:0] core_hburst,
  input  logic [NUM_CORES-1:0] core_hmastlock,
  input  logic [NUM_CORES*HASTI_PROT_WIDTH-1:0] core_hprot,
  input  logic [NUM_CORES*HASTI_TRANS_WIDTH-1:0] core_htrans,
  input  logic [NUM_CORES*BUS_WIDTH-1:0] core_hwdata,
  output logic [NUM_CORES*BUS_WIDTH-1:0] core_hrdata,
  output logic [NUM_CORES-1:0] core_hready,
  output logic [NUM_CORES*HASTI_RESP_WIDTH-1:0] core_hresp,
  output logic [ADDR_WIDTH-1:0] dmem_haddr,
  output logic dmem_hwrite,
  output logic [HASTI_SIZE_WIDTH-1:0] dmem_hsize,
  output logic [HASTI_BURST_WIDTH-1:0] dmem_hburst,
  output logic dmem_hmastlock,
  output logic [HASTI_PROT_WIDTH-1:0] dmem_hprot,
  output logic [HASTI_TRANS_WIDTH-1:0] dmem_htrans,
  output logic [BUS_WIDTH-1:0] dmem_hwdata,
  input  logic [BUS_WIDTH-1:0] dmem_hrdata,
  input  logic dmem_hready,
  input  logic [HASTI_RESP_WIDTH-1:0] dmem_hresp,
  input  logic [CORE_IDX_WIDTH-1:0] next_core
);

  localparam int N  = NUM_CORES;
  localparam int IW = CORE_IDX_WIDTH;

  typedef logic [IW-1:0] idx_t;

  logic [ADDR_WIDTH-1:0]        haddr_a  [N];
  logic [HASTI_SIZE_WIDTH-1:0]  hsize_a  [N];
  logic [HASTI_BURST_WIDTH-1:0] hburst_a [N];
  logic [HASTI_PROT_WIDTH-1:0]  hprot_a  [N];
  logic [HASTI_TRANS_WIDTH-1:0] htrans_a [N];
  logic [BUS_WIDTH-1:0]         hwdata_a [N];
  logic [N-1:0] req;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      haddr_a[i]  = core_haddr[ADDR_WIDTH*i +: ADDR_WIDTH];
      hsize_a[i]  = core_hsize[HASTI_SIZE_WIDTH*i +: HASTI_SIZE_WIDTH];
      hburst_a[i] = core_hburst[HASTI_BURST_WIDTH*i +: HASTI_BURST_WIDTH];
      hprot_a[i]  = core_hprot[HASTI_PROT_WIDTH*i +: HASTI_PROT_WIDTH];
      htrans_a[i] = core_htrans[HASTI_TRANS_WIDTH*i +: HASTI_TRANS_WIDTH];
      hwdata_a[i] = core_hwdata[BUS_WIDTH*i +: BUS_WIDTH];
      req[i]      = hasti_is_req(htrans_a[i]);
    end
  end

  idx_t gnt_q, gnt_d;
  idx_t rr_ptr_q, rr_ptr_d;
  logic dp_valid_q, dp_valid_d;
  idx_t dp_owner_q, dp_owner_d;
  logic [N-1:0] held_valid_q, held_valid_d;
  logic [N-1:0][BUS_WIDTH-1:0] held_rdata_q, held_rdata_d;
  logic [N-1:0] held_resp_q, held_resp_d;

  idx_t pick_idx;
  logic pick_vld;

`ifdef VSCALE_ARB_FORCED_SCHED_EN
  assign pick_idx = next_core;
  assign pick_vld = req[next_core];
`else
  vscale_rr_pick #(
    .N  (N),
    .IW (IW)
  ) u_pick (
    .req_i     (req),
    .ptr_i     (rr_ptr_q),
    .gnt_idx_o (pick_idx),
    .gnt_vld_o (pick_vld)
  );

  logic unused_next_core;
  assign unused_next_core = ^next_core;
`endif

  idx_t gnt, sel, wsel;
  logic gnt_vld, accept;

  // A stalled bus keeps the last accepted master on the address lines.
  always_comb begin
    if (dmem_hready) begin
      gnt     = pick_idx;
      gnt_vld = pick_vld;
    end else begin
      gnt     = gnt_q;
      gnt_vld = req[gnt_q];
    end
    accept = gnt_vld & dmem_hready;
    sel    = gnt_vld ? gnt : '0;
    wsel   = dp_valid_q ? dp_owner_q : '0;
  end

  assign dmem_haddr     = haddr_a[sel];
  assign dmem_hwrite    = core_hwrite[sel];
  assign dmem_hsize     = hsize_a[sel];
  assign dmem_hburst    = hburst_a[sel];
  assign dmem_hmastlock = core_hmastlock[sel];
  assign dmem_hprot     = hprot_a[sel];
  assign dmem_htrans    = (hresetn && gnt_vld) ?
                          htrans_a[sel] : HASTI_TRANS_IDLE;
  assign dmem_hwdata    = hwdata_a[wsel];

  logic [N-1:0] rdy;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      if (req[i])
        rdy[i] = gnt_vld && (gnt == IW'(i)) && dmem_hready;
      else if (held_valid_q[i])
        rdy[i] = 1'b1;
      else if (dp_valid_q && (dp_owner_q == IW'(i)))
        rdy[i] = dmem_hready;
      else
        rdy[i] = 1'b1;
    end
  end

  always_comb begin
    core_hrdata = '0;
    core_hresp  = '0;
    core_hready = '1;
    for (int i = 0; i < N; i++) begin
      if (hresetn) begin
        core_hready[i] = rdy[i];
        core_hresp[i]  = held_valid_q[i] ?
                         held_resp_q[i] : dmem_hresp;
        core_hrdata[BUS_WIDTH*i +: BUS_WIDTH] =
          held_valid_q[i] ? held_rdata_q[i] : dmem_hrdata;
      end else begin
        core_hresp[i] = HASTI_RESP_OKAY;
      end
    end
  end

  always_comb begin
    gnt_d        = gnt_q;
    rr_ptr_d     = rr_ptr_q;
    dp_valid_d   = dp_valid_q;
    dp_owner_d   = dp_owner_q;
    held_valid_d = held_valid_q;
    held_rdata_d = held_rdata_q;
    held_resp_d  = held_resp_q;
    if (accept) begin
      gnt_d      = gnt;
      rr_ptr_d   = gnt;
      dp_valid_d = 1'b1;
      dp_owner_d = gnt;
    end else if (dmem_hready) begin
      dp_valid_d = 1'b0;
    end
    for (int i = 0; i < N; i++)
      if (held_valid_q[i] && rdy[i])
        held_valid_d[i] = 1'b0;
    // Owner is stalled on its next request: keep its response.
    if (dp_valid_q && dmem_hready && !rdy[dp_owner_q]) begin
      held_valid_d[dp_owner_q] = 1'b1;
      held_rdata_d[dp_owner_q] = dmem_hrdata;
      held_resp_d[dp_owner_q]  = dmem_hresp;
    end
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      gnt_q        <= '0;
      rr_ptr_q     <= IW'(N-1);
      dp_valid_q   <= 1'b0;
      dp_owner_q   <= '0;
      held_valid_q <= '0;
      held_rdata_q <= '0;
      held_resp_q  <= '0;
    end else begin
      gnt_q        <= gnt_d;
      rr_ptr_q     <= rr_ptr_d;
      dp_valid_q   <= dp_valid_d;
      dp_owner_q   <= dp_owner_d;
      held_valid_q <= held_valid_d;
      held_rdata_q <= held_rdata_d;
      held_resp_q  <= held_resp_d;
    end
  end

endmodule

// File: tb/tb_vscale_rr_dmem_arbiter.sv
// Bench for vscale_rr_dmem_arbiter: directed cases plus random traffic
// checked cycle by cycle against a small behavioural model.
module tb_vscale_rr_dmem_arbiter;

  localparam int N  = 3;
  localparam int AW = 32;
  localparam int BW = 32;
  localparam int IW = $clog2(N);

  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] NONSEQ = 2'b10;

  logic hclk = 1'b0;
  logic hresetn;
  logic [N*AW-1:0] core_haddr;
  logic [N-1:0]    core_hwrite;
  logic [N*3-1:0]  core_hsize;
  logic [N*3-1:0]  core_hburst;
  logic [N-1:0]    core_hmastlock;
  logic [N*4-1:0]  core_hprot;
  logic [N*2-1:0]  core_htrans;
  logic [N*BW-1:0] core_hwdata;
  logic [N*BW-1:0] core_hrdata;
  logic [N-1:0]    core_hready;
  logic [N-1:0]    core_hresp;
  logic [AW-1:0]   dmem_haddr;
  logic            dmem_hwrite;
  logic [2:0]      dmem_hsize;
  logic [2:0]      dmem_hburst;
  logic            dmem_hmastlock;
  logic [3:0]      dmem_hprot;
  logic [1:0]      dmem_htrans;
  logic [BW-1:0]   dmem_hwdata;
  logic [IW-1:0]   nxt;

  logic [AW-1:0] ad [N];
  logic [BW-1:0] wd [N];
  logic [1:0]    tr [N];
  logic          wr [N];
  logic [2:0]    sz [N];
  logic          hrdy;
  logic [BW-1:0] rd;
  logic          rsp;

  int ncmp = 0;
  int nerr = 0;

  int   m_last, m_gq, m_own;
  bit   m_dpv;
  bit   m_held [N];
  logic [BW-1:0] m_hd [N];
  logic m_hr [N];

  always #5 hclk = ~hclk;

  always_comb begin
    core_haddr = '0; core_hwdata = '0; core_htrans = '0;
    core_hsize = '0; core_hburst = '0; core_hprot = '0;
    core_hwrite = '0; core_hmastlock = '0;
    for (int i = 0; i < N; i++) begin
      core_haddr[AW*i +: AW]  = ad[i];
      core_hwdata[BW*i +: BW] = wd[i];
      core_htrans[2*i +: 2]   = tr[i];
      core_hsize[3*i +: 3]    = sz[i];
      core_hprot[4*i +: 4]    = 4'(i + 1);
      core_hwrite[i]          = wr[i];
    end
  end

  vscale_rr_dmem_arbiter #(
    .NUM_CORES (N), .ADDR_WIDTH (AW), .BUS_WIDTH (BW)
  ) dut (
    .hclk (hclk), .hresetn (hresetn),
    .core_haddr (core_haddr), .core_hwrite (core_hwrite),
    .core_hsize (core_hsize), .core_hburst (core_hburst),
    .core_hmastlock (core_hmastlock), .core_hprot (core_hprot),
    .core_htrans (core_htrans), .core_hwdata (core_hwdata),
    .core_hrdata (core_hrdata), .core_hready (core_hready),
    .core_hresp (core_hresp),
    .dmem_haddr (dmem_haddr), .dmem_hwrite (dmem_hwrite),
    .dmem_hsize (dmem_hsize), .dmem_hburst (dmem_hburst),
    .dmem_hmastlock (dmem_hmastlock), .dmem_hprot (dmem_hprot),
    .dmem_htrans (dmem_htrans), .dmem_hwdata (dmem_hwdata),
    .dmem_hrdata (rd), .dmem_hready (hrdy), .dmem_hresp (rsp),
    .next_core (nxt)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    ncmp++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle_all();
    for (int i = 0; i < N; i++) begin
      tr[i] = IDLE; ad[i] = 32'h1000 * (i + 1);
      wd[i] = 32'hA000_0000 + i; wr[i] = 1'b0; sz[i] = 3'd2;
    end
    rsp = 1'b0;
  endtask

  task automatic model_reset();
    m_last = N - 1; m_gq = 0; m_own = 0; m_dpv = 0;
    for (int i = 0; i < N; i++) m_held[i] = 0;
  endtask

  task automatic rst_check(input string t);
    chk({t, ".rst_htrans"}, dmem_htrans, IDLE);
    chk({t, ".rst_hready"}, core_hready, {N{1'b1}});
    chk({t, ".rst_hresp"}, core_hresp, '0);
    chk({t, ".rst_hrdata"}, core_hrdata, '0);
  endtask

  // Called at a falling edge; leaves the bench at the next falling edge.
  task automatic do_reset();
    hresetn = 1'b0;
    rd = 32'h5A5A_5A5A;
    #1 rst_check("reset");
    @(posedge hclk);
    #1 rst_check("reset_edge");
    @(negedge hclk);
    hresetn = 1'b1;
    model_reset();
  endtask

  // One bus cycle: predict outputs from the rules, compare, advance model.
  task automatic step(input string t);
    bit r [N];
    bit er [N];
    bit gv;
    int g, sel, ws;
    #1;
    for (int i = 0; i < N; i++) r[i] = tr[i][1];
    gv = 0; g = m_gq;
    if (hrdy) begin
`ifdef VSCALE_ARB_FORCED_SCHED_EN
      if (r[nxt]) begin gv = 1; g = int'(nxt); end
`else
      for (int k = 1; k <= N; k++)
        if (!gv && r[(m_last + k) % N]) begin
          gv = 1; g = (m_last + k) % N;
        end
`endif
    end else begin
      gv = r[m_gq];
    end
    sel = gv ? g : 0;
    ws  = m_dpv ? m_own : 0;
    for (int i = 0; i < N; i++) begin
      if (r[i]) er[i] = gv && (g == i) && hrdy;
      else if (m_held[i]) er[i] = 1;
      else if (m_dpv && m_own == i) er[i] = hrdy;
      else er[i] = 1;
    end
    chk({t, ".htrans"}, dmem_htrans, gv ? tr[g] : IDLE);
    chk({t, ".haddr"}, dmem_haddr, ad[sel]);
    chk({t, ".hwrite"}, dmem_hwrite, wr[sel]);
    chk({t, ".hsize"}, dmem_hsize, sz[sel]);
    chk({t, ".hwdata"}, dmem_hwdata, wd[ws]);
    for (int i = 0; i < N; i++) begin
      chk($sformatf("%s.hready%0d", t, i), core_hready[i], er[i]);
      chk($sformatf("%s.hrdata%0d", t, i), core_hrdata[BW*i +: BW],
          m_held[i] ? m_hd[i] : rd);
      chk($sformatf("%s.hresp%0d", t, i), core_hresp[i],
          m_held[i] ? m_hr[i] : rsp);
    end
    @(posedge hclk);
    for (int i = 0; i < N; i++)
      if (m_held[i] && er[i]) m_held[i] = 0;
    if (m_dpv && hrdy && !er[m_own]) begin
      m_held[m_own] = 1; m_hd[m_own] = rd; m_hr[m_own] = rsp;
    end
    if (gv && hrdy) begin
      m_last = g; m_gq = g; m_own = g; m_dpv = 1;
    end else if (hrdy) begin
      m_dpv = 0;
    end
    @(negedge hclk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    hresetn = 1'b0; hrdy = 1'b1; nxt = '0; rd = '0;
    idle_all();
    @(negedge hclk);
    do_reset();

`ifndef VSCALE_ARB_FORCED_SCHED_EN
    // single read from core 1
    tr[1] = NONSEQ; ad[1] = 32'h100;
    #1 chk("t1.hready1", core_hready[1], 1'b1);
    chk("t1.haddr", dmem_haddr, 32'h100);
    step("t1a");
    tr[1] = IDLE; rd = 32'hCAFE_0001;
    #1 chk("t1.hrdata1", core_hrdata[BW +: BW], 32'hCAFE_0001);
    step("t1b");

    // two cores requesting every cycle alternate
    do_reset(); idle_all(); hrdy = 1'b1;
    tr[0] = NONSEQ; tr[1] = NONSEQ;
    ad[0] = 32'h200; ad[1] = 32'h300;
    for (int c = 0; c < 4; c++) begin
      #1 chk("t2.haddr", dmem_haddr, (c % 2) ? 32'h300 : 32'h200);
      chk("t2.hready0", core_hready[0], (c % 2) == 0);
      chk("t2.hready1", core_hready[1], (c % 2) == 1);
      step("t2");
    end

    // response held while core 0 loses to core 1
    do_reset(); idle_all();
    tr[0] = NONSEQ; step("t3a");
    tr[1] = NONSEQ; rd = 32'h11;
    #1 chk("t3.hready0_lost", core_hready[0], 1'b0);
    step("t3b");
    rd = 32'h22;
    #1 chk("t3.hready0_gnt", core_hready[0], 1'b1);
    chk("t3.hrdata0_held", core_hrdata[BW-1:0], 32'h11);
    step("t3c");

    // wait states keep the address stable, core 1 queued
    do_reset(); idle_all();
    tr[0] = NONSEQ; ad[0] = 32'h500; step("t4a");
    tr[0] = IDLE; tr[1] = NONSEQ; ad[1] = 32'h44; hrdy = 1'b0;
    for (int c = 0; c < 2; c++) begin
      #1 chk("t4.haddr_wait", dmem_haddr, 32'h500);
      chk("t4.hready1_wait", core_hready[1], 1'b0);
      step("t4w");
    end
    hrdy = 1'b1;
    #1 chk("t4.haddr_acc", dmem_haddr, 32'h44);
    chk("t4.htrans_acc", dmem_htrans, NONSEQ);
    chk("t4.hready1_acc", core_hready[1], 1'b1);
    step("t4b");

    // write data follows the data-phase owner
    do_reset(); idle_all();
    tr[1] = NONSEQ; wr[1] = 1'b1; ad[1] = 32'h40; step("t5a");
    tr[1] = IDLE; wd[1] = 32'hDEAD_BEEF;
    #1 chk("t5.hwdata", dmem_hwdata, 32'hDEAD_BEEF);
    step("t5b");

    // reset in the middle of a data phase
    do_reset(); idle_all();
    tr[0] = NONSEQ; tr[1] = NONSEQ;
    step("t6a"); step("t6b");
    hrdy = 1'b0; hresetn = 1'b0; rd = 32'h77;
    #1 rst_check("t6");
    @(posedge hclk);
    #1 rst_check("t6_edge");
    @(negedge hclk);
    hresetn = 1'b1; hrdy = 1'b1; model_reset();
    #1 chk("t6.haddr_first", dmem_haddr, ad[0]);
    chk("t6.hready0_first", core_hready[0], 1'b1);
    step("t6c");
`else
    // forced schedule
    do_reset(); idle_all(); hrdy = 1'b1;
    tr[0] = NONSEQ; tr[1] = NONSEQ; nxt = 1;
    #1 chk("t7.haddr", dmem_haddr, ad[1]);
    chk("t7.hready0", core_hready[0], 1'b0);
    step("t7a");
    tr[0] = IDLE; nxt = 0;
    #1 chk("t7.htrans_idle", dmem_htrans, IDLE);
    step("t7b");
`endif

    // random traffic
    do_reset();
    for (int n = 0; n < 600; n++) begin
      if (n % 150 == 149) do_reset();
      for (int i = 0; i < N; i++) begin
        tr[i] = ($urandom_range(0, 9) < 6) ?
                2'($urandom_range(2, 3)) : 2'($urandom_range(0, 1));
        ad[i] = $urandom; wd[i] = $urandom;
        wr[i] = 1'($urandom_range(0, 1));
        sz[i] = 3'($urandom_range(0, 7));
      end
      hrdy = ($urandom_range(0, 3) != 0);
      rd   = $urandom;
      rsp  = 1'($urandom_range(0, 1));
      nxt  = IW'($urandom_range(0, N - 1));
      step("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nerr);
    $finish;
  end

endmodule
